// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller.
// Holds the controller state encodings, the default datapath widths and the
// tuning word that silences the DDS output.
package dds_ctrl_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_DWELL_W = 16;
    localparam int DEF_CNT_W   = 12;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RUN    = ST_RUN,
        FINISH = ST_FINISH
    } state_t;

    localparam logic [DEF_PHASE_W-1:0] SILENCE_WORD = '0;

endpackage

// File: rtl/dds_dwell_timer.sv
// Per-tone dwell timer: a loadable down-counter that stops at zero.
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   load         load load_val into the counter (has priority over counting)
//   load_val     reload value, i.e. dwell length minus one
//   enable       count down while non-zero; qualifies expire
//   expire       high when enabled and the count has reached zero
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int W = DEF_DWELL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer for the phase-accumulator DDS.
// Steps the tuning word from a start word by a signed step for steps+1 tones,
// holding each tone for a fixed dwell, and gates the OOK enable meanwhile.
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   start, abort      sweep request (IDLE only) / level-sensitive abort
//   cfg_*             sweep configuration, captured when a sweep starts
//   freq_word         tuning word to the accumulator adder
//   tw_load           pulse in the first cycle of each new tuning word
//   ook_en, busy      high while the sweep runs
//   tone_idx          index of the tone being output
//   done              one-cycle pulse on normal completion
//
// state  | meaning
// IDLE   | silent, waiting for start
// RUN    | presenting tones, dwell timer running
// FINISH | one-cycle done pulse, outputs silent
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start_word,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]   cfg_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    output logic [PHASE_W-1:0] freq_word,
    output logic               tw_load,
    output logic               ook_en,
    output logic [CNT_W-1:0]   tone_idx,
    output logic               busy,
    output logic               done
);

    state_t state_q, state_d;

    logic [PHASE_W-1:0] start_q, step_q;
    logic [CNT_W-1:0]   steps_q;
    logic [DWELL_W-1:0] reload_q;
    logic               loop_q;

    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               tw_q, tw_d;
    logic               ook_q, ook_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic [DWELL_W-1:0] cfg_reload;
    logic               expire;

    // A dwell of zero behaves as one cycle, so both map to a reload of zero.
    assign cfg_reload = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

    dds_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (state_q == RUN),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            freq_q  <= SILENCE_WORD;
            idx_q   <= '0;
            tw_q    <= 1'b0;
            ook_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            idx_q   <= idx_d;
            tw_q    <= tw_d;
            ook_q   <= ook_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q  <= '0;
            step_q   <= '0;
            steps_q  <= '0;
            reload_q <= '0;
            loop_q   <= 1'b0;
        end else if (accept) begin
            start_q  <= cfg_start_word;
            step_q   <= cfg_step;
            steps_q  <= cfg_steps;
            reload_q <= cfg_reload;
            loop_q   <= cfg_loop;
        end
    end

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        idx_d    = idx_q;
        tw_d     = 1'b0;
        ook_d    = ook_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = reload_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    accept   = 1'b1;
                    state_d  = RUN;
                    freq_d   = cfg_start_word;
                    idx_d    = '0;
                    tw_d     = 1'b1;
                    ook_d    = 1'b1;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = cfg_reload;
                end
            end
            RUN: begin
                // Abort is checked first so it wins over a coincident expiry.
                if (abort) begin
                    state_d = IDLE;
                    freq_d  = SILENCE_WORD;
                    idx_d   = '0;
                    ook_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (expire) begin
                    if (idx_q != steps_q) begin
                        freq_d   = freq_q + step_q;
                        idx_d    = idx_q + CNT_W'(1);
                        tw_d     = 1'b1;
                        tmr_load = 1'b1;
                    end else if (loop_q) begin
                        freq_d   = start_q;
                        idx_d    = '0;
                        tw_d     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = FINISH;
                        freq_d  = SILENCE_WORD;
                        idx_d   = '0;
                        ook_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                freq_d  = SILENCE_WORD;
                idx_d   = '0;
                ook_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign freq_word = freq_q;
    assign tw_load   = tw_q;
    assign ook_en    = ook_q;
    assign tone_idx  = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_start_word;
    logic [31:0] cfg_step;
    logic [11:0] cfg_steps;
    logic [15:0] cfg_dwell;
    logic        cfg_loop;
    logic [31:0] freq_word;
    logic        tw_load;
    logic        ook_en;
    logic [11:0] tone_idx;
    logic        busy;
    logic        done;

    int total_n = 0;
    int bad_n   = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_start_word (cfg_start_word),
        .cfg_step       (cfg_step),
        .cfg_steps      (cfg_steps),
        .cfg_dwell      (cfg_dwell),
        .cfg_loop       (cfg_loop),
        .freq_word      (freq_word),
        .tw_load        (tw_load),
        .ook_en         (ook_en),
        .tone_idx       (tone_idx),
        .busy           (busy),
        .done           (done)
    );

    // Runs one sweep and compares every output each cycle against the
    // tone schedule: tone t = (j / D) mod (steps+1) holds start + t*step.
    // j = 0 is the first cycle after the edge that samples start.
    // abort_at >= 0 raises abort during cycle abort_at; poke re-issues start
    // with scrambled cfg mid-sweep and during the done cycle.
    task automatic test_sweep(input string name, input logic [31:0] sw, input logic [31:0] st,
                              input int steps, input int dwell, input bit loop,
                              input int ncyc, input int abort_at, input bit poke);
        int d, tot, tone;
        logic [31:0] ew;
        logic [11:0] eidx;
        logic etw, eook, ebusy, edone;
        d   = (dwell == 0) ? 1 : dwell;
        tot = (steps + 1) * d;
        @(negedge clk);
        cfg_start_word = sw;
        cfg_step       = st;
        cfg_steps      = 12'(steps);
        cfg_dwell      = 16'(dwell);
        cfg_loop       = loop;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            ew = 32'h0; eidx = 12'h0; etw = 1'b0; eook = 1'b0; ebusy = 1'b0; edone = 1'b0;
            if (abort_at >= 0 && j > abort_at) begin
                // silent idle
            end else if (loop || j < tot) begin
                tone  = (j / d) % (steps + 1);
                ew    = sw + st * 32'(tone);
                eidx  = 12'(tone);
                etw   = ((j % d) == 0);
                eook  = 1'b1;
                ebusy = 1'b1;
            end else if (j == tot) begin
                edone = 1'b1;
            end
            total_n++;
            if ({freq_word, tw_load, ook_en, tone_idx, busy, done} !== {ew, etw, eook, eidx, ebusy, edone}) begin
                bad_n++;
                $display("FAIL %s cyc=%0d got word=%h tw=%b ook=%b idx=%0d busy=%b done=%b exp word=%h tw=%b ook=%b idx=%0d busy=%b done=%b",
                         name, j, freq_word, tw_load, ook_en, tone_idx, busy, done, ew, etw, eook, eidx, ebusy, edone);
            end
            abort = (j == abort_at);
            if (poke && j == 2) begin
                start          = 1'b1;
                cfg_step       = ~st;
                cfg_start_word = ~sw;
                cfg_steps      = 12'(steps + 2);
                cfg_dwell      = 16'(dwell + 3);
                cfg_loop       = ~loop;
            end else if (poke && j == tot) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; abort = 1'b0;
        cfg_start_word = 32'h1234_5678; cfg_step = 32'h1; cfg_steps = 12'd2;
        cfg_dwell = 16'd3; cfg_loop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_n++;
        if ({freq_word, tw_load, ook_en, tone_idx, busy, done} !== 48'h0) begin
            bad_n++;
            $display("FAIL reset got word=%h tw=%b ook=%b idx=%0d busy=%b done=%b exp all zero",
                     freq_word, tw_load, ook_en, tone_idx, busy, done);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        test_sweep("basic", 32'h0100_0000, 32'h0080_0000, 3, 4, 1'b0, 19, -1, 1'b0);
    endtask

    task automatic test_wrap();
        test_sweep("wrap_pos", 32'hFFFF_FF00, 32'h0000_0200, 1, 1, 1'b0, 5, -1, 1'b0);
        test_sweep("wrap_neg", 32'h0000_0100, 32'hFFFF_FE00, 1, 1, 1'b0, 5, -1, 1'b0);
    endtask

    task automatic test_min_dwell();
        test_sweep("dwell0_steps0", 32'hA5A5_0000, 32'h0000_1000, 0, 0, 1'b0, 4, -1, 1'b0);
        test_sweep("steps0_loop", 32'h0F0F_0F0F, 32'h0000_0040, 0, 3, 1'b1, 11, 9, 1'b0);
    endtask

    task automatic test_loop_abort();
        test_sweep("loop_abort", 32'h2000_0000, 32'h0010_0000, 1, 2, 1'b1, 10, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_sweep("busy_cfg_change", 32'h0100_0000, 32'h0080_0000, 3, 4, 1'b0, 19, -1, 1'b1);
        test_sweep("after_busy", 32'h0300_0000, 32'h0001_0000, 2, 2, 1'b0, 8, -1, 1'b0);
        // start with abort in IDLE is dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total_n++;
        if ({freq_word, ook_en, busy, tw_load, done} !== 36'h0) begin
            bad_n++;
            $display("FAIL start_with_abort got word=%h ook=%b busy=%b tw=%b done=%b exp all zero",
                     freq_word, ook_en, busy, tw_load, done);
        end
        @(negedge clk);
        total_n++;
        if (busy !== 1'b0) begin
            bad_n++;
            $display("FAIL start_with_abort_late got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cfg_start_word = 32'h0100_0000; cfg_step = 32'h0080_0000;
        cfg_steps = 12'd3; cfg_dwell = 16'd4; cfg_loop = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_n++;
        if ({freq_word, tw_load, ook_en, tone_idx, busy, done} !== 48'h0) begin
            bad_n++;
            $display("FAIL reset_mid got word=%h tw=%b ook=%b idx=%0d busy=%b done=%b exp all zero",
                     freq_word, tw_load, ook_en, tone_idx, busy, done);
        end
        rst = 1'b1;
        test_sweep("after_reset", 32'h0100_0000, 32'h0080_0000, 3, 4, 1'b0, 19, -1, 1'b0);
    endtask

    task automatic test_random();
        int steps, dwell, ab, ncyc, d;
        bit loop;
        for (int it = 0; it < 25; it++) begin
            steps = $urandom_range(0, 5);
            dwell = $urandom_range(0, 5);
            loop  = ($urandom_range(0, 3) == 0);
            d     = (dwell == 0) ? 1 : dwell;
            ncyc  = (steps + 1) * d + 3;
            ab    = -1;
            if (loop) begin
                ncyc = 2 * (steps + 1) * d + 4;
                ab   = ncyc - 3;
            end else if ($urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, (steps + 1) * d - 1);
            end
            test_sweep("random", $urandom, $urandom, steps, dwell, loop, ncyc, ab, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_start_word = '0; cfg_step = '0; cfg_steps = '0; cfg_dwell = '0; cfg_loop = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_min_dwell();
        test_loop_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
